// File: rtl/i2c_pkg.sv
// Shared I2C definitions: conditioner FSM state encodings and the idle line level.
// No latency; declarations only.
// No backpressure; declarations only.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_UNARMED = 2'd0,
        ST_IDLE    = 2'd1,
        ST_BUSY    = 2'd2
    } state_t;

    localparam logic I2C_LINE_IDLE = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: synchroniser chain, then a run-length deglitcher with registered edge strobes.
// Latency is SYNC_STAGES+FILTER_CYCLES clocks from pin to out_line, and out_rise/out_fall align with it.
// No backpressure: the line is sampled every clock.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic in_line,
    output logic out_sync,
    output logic out_line,
    output logic out_rise,
    output logic out_fall
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;

    assign out_sync = sync[SYNC_STAGES-1];

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sync     <= {SYNC_STAGES{I2C_LINE_IDLE}};
            cnt      <= '0;
            out_line <= I2C_LINE_IDLE;
            out_rise <= 1'b0;
            out_fall <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], in_line};
            out_rise <= 1'b0;
            out_fall <= 1'b0;
            if (out_sync == out_line) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                // FILTER_CYCLES disagreeing samples in a row: accept the new level.
                out_line <= out_sync;
                out_rise <= out_sync;
                out_fall <= ~out_sync;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Conditions raw SCL/SDA into filtered levels, SCL edge strobes, START/STOP strobes and bus-busy.
// Latency is SYNC_STAGES+FILTER_CYCLES clocks pin-to-strobe; bus-busy follows one clock later.
// No backpressure: strobes are single-cycle and cannot be stalled.
module i2c_bus_conditioner
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic in_scl,
    input  logic in_sda,
    output logic out_scl,
    output logic out_sda,
    output logic out_scl_rise,
    output logic out_scl_fall,
    output logic out_start,
    output logic out_stop,
    output logic out_bus_busy
);

    localparam int ARM_CYCLES = SYNC_STAGES + FILTER_CYCLES;
    localparam int AW         = $clog2(ARM_CYCLES + 1);

    logic   s_scl, s_sda;
    logic   scl_rise, scl_fall, sda_rise, sda_fall;
    logic   start_cond, stop_cond, quiet, armed;
    state_t state, state_nxt;
    logic [AW-1:0] arm_cnt, arm_cnt_nxt;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_scl (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .in_line  (in_scl),
        .out_sync (s_scl),
        .out_line (out_scl),
        .out_rise (scl_rise),
        .out_fall (scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sda (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .in_line  (in_sda),
        .out_sync (s_sda),
        .out_line (out_sda),
        .out_rise (sda_rise),
        .out_fall (sda_fall)
    );

    // out_scl high with no rise this cycle means SCL was steady high across the SDA edge.
    assign start_cond = sda_fall & out_scl & ~scl_rise;
    assign stop_cond  = sda_rise & out_scl & ~scl_rise;
    assign quiet      = s_scl & s_sda & out_scl & out_sda;
    assign armed      = (state != ST_UNARMED);

    always_comb begin
        state_nxt    = state;
        arm_cnt_nxt  = arm_cnt;
        out_start    = armed & start_cond;
        out_stop     = armed & stop_cond;
        out_scl_rise = armed & scl_rise;
        out_scl_fall = armed & scl_fall;
        case (state)
            ST_UNARMED: begin
                if (!quiet) begin
                    arm_cnt_nxt = '0;
                end else if (arm_cnt == AW'(ARM_CYCLES - 1)) begin
                    state_nxt   = ST_IDLE;
                    arm_cnt_nxt = '0;
                end else begin
                    arm_cnt_nxt = arm_cnt + 1'b1;
                end
            end
            ST_IDLE: if (start_cond) state_nxt = ST_BUSY;
            ST_BUSY: if (stop_cond) state_nxt = ST_IDLE;
            default: state_nxt = ST_UNARMED;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state        <= ST_UNARMED;
            arm_cnt      <= '0;
            out_bus_busy <= 1'b0;
        end else begin
            state        <= state_nxt;
            arm_cnt      <= arm_cnt_nxt;
            out_bus_busy <= (state_nxt == ST_BUSY);
        end
    end

endmodule
